// File: rtl/mix_col_seq.sv
`default_nettype none
// ============================================================================
//  Module   : mix_col_seq
//  Purpose  : Sequential AES MixColumns / InvMixColumns engine. Accepts one
//             128-bit state per valid/ready handshake and transforms
//             COLS_PER_CYCLE columns per clock. The result is presented on a
//             valid/ready output port. Forward/inverse mode is chosen per
//             block.
//  Params   : COLS_PER_CYCLE - columns per clock (1, 2 or 4)
//             INV_EN         - 1 builds the inverse datapath, 0 drops it
//  Ports    : clk, rst_n            - clock, async active-low reset
//             in_valid/in_ready     - input handshake
//             in_data[127:0]        - state, column i = bits [32i+31:32i]
//             in_inv                - 0 MixColumns, 1 InvMixColumns
//             out_valid/out_ready   - output handshake
//             out_data[127:0]       - transformed state
//             busy                  - engine is transforming columns
//  Revision : 1.0 - initial release
// ============================================================================
module mix_col_seq #(
    parameter int COLS_PER_CYCLE = 1,
    parameter bit INV_EN         = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic         in_inv,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    localparam int         C_NUM_GROUPS = 4 / COLS_PER_CYCLE;
    localparam logic [1:0] C_LAST_CNT   = 2'(C_NUM_GROUPS - 1);

    generate
        if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
            $error("mix_col_seq: COLS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // GF(2^8) helpers, field polynomial x^8+x^4+x^3+x+1
    // ------------------------------------------------------------------------
    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    endfunction

    function automatic logic [31:0] col_fwd(input logic [31:0] col);
        logic [7:0] b0, b1, b2, b3;
        logic [7:0] c0, c1, c2, c3;
        b0 = col[31:24];
        b1 = col[23:16];
        b2 = col[15:8];
        b3 = col[7:0];
        // 3x = 2x ^ x
        c0 = xtime(b0) ^ (xtime(b1) ^ b1) ^ b2 ^ b3;
        c1 = b0 ^ xtime(b1) ^ (xtime(b2) ^ b2) ^ b3;
        c2 = b0 ^ b1 ^ xtime(b2) ^ (xtime(b3) ^ b3);
        c3 = (xtime(b0) ^ b0) ^ b1 ^ b2 ^ xtime(b3);
        return {c0, c1, c2, c3};
    endfunction

    // Multiples 9/11/13/14 built from x2, x4, x8 of one byte:
    //   9 = 8+1, 11 = 8+2+1, 13 = 8+4+1, 14 = 8+4+2
    function automatic logic [31:0] col_inv(input logic [31:0] col);
        logic [7:0] b   [4];
        logic [7:0] m9  [4];
        logic [7:0] m11 [4];
        logic [7:0] m13 [4];
        logic [7:0] m14 [4];
        logic [7:0] x2, x4, x8;
        b[0] = col[31:24];
        b[1] = col[23:16];
        b[2] = col[15:8];
        b[3] = col[7:0];
        for (int j = 0; j < 4; j++) begin
            x2     = xtime(b[j]);
            x4     = xtime(x2);
            x8     = xtime(x4);
            m9[j]  = x8 ^ b[j];
            m11[j] = x8 ^ x2 ^ b[j];
            m13[j] = x8 ^ x4 ^ b[j];
            m14[j] = x8 ^ x4 ^ x2;
        end
        return {m14[0] ^ m11[1] ^ m13[2] ^ m9[3],
                m9[0]  ^ m14[1] ^ m11[2] ^ m13[3],
                m13[0] ^ m9[1]  ^ m14[2] ^ m11[3],
                m11[0] ^ m13[1] ^ m9[2]  ^ m14[3]};
    endfunction

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t        state_q, state_d;
    logic [1:0]    cnt_q,   cnt_d;
    logic [127:0]  data_q,  data_d;   // work register, transformed in place
    logic          inv_q,   inv_d;

    // ------------------------------------------------------------------------
    // Column datapath: one lane per column handled this cycle. Transforming
    // in place is safe because each column reads only its own, still
    // untouched, bytes.
    // ------------------------------------------------------------------------
    logic [1:0]  w_col_idx [COLS_PER_CYCLE];
    logic [31:0] w_col_in  [COLS_PER_CYCLE];
    logic [31:0] w_col_out [COLS_PER_CYCLE];

    generate
        for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
            // For COLS_PER_CYCLE=4 cnt is always 0, so truncation is harmless
            assign w_col_idx[g] = 2'((int'(cnt_q) * COLS_PER_CYCLE) + g);
            assign w_col_in[g]  = data_q[{w_col_idx[g], 5'b00000} +: 32];

            if (INV_EN) begin : g_inv
                assign w_col_out[g] = inv_q ? col_inv(w_col_in[g]) : col_fwd(w_col_in[g]);
            end else begin : g_fwd_only
                assign w_col_out[g] = col_fwd(w_col_in[g]);
            end
        end
    endgenerate

    // ------------------------------------------------------------------------
    // FSM next state and outputs
    // ------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        inv_d     = inv_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
            end
            ST_BUSY: begin
                busy = 1'b1;
                for (int g = 0; g < COLS_PER_CYCLE; g++) begin
                    data_d[{w_col_idx[g], 5'b00000} +: 32] = w_col_out[g];
                end
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == C_LAST_CNT) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                // Only combinational path: downstream ready frees the slot
                in_ready  = out_ready;
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Accept overrides the IDLE/DONE transition above
        if (in_ready && in_valid) begin
            data_d  = in_data;
            inv_d   = in_inv & INV_EN;
            cnt_d   = 2'd0;
            state_d = ST_BUSY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 2'd0;
            data_q  <= '0;
            inv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            inv_q   <= inv_d;
        end
    end

    assign out_data = data_q;

endmodule
`default_nettype wire

// File: tb/tb_mix_col_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mix_col_seq
//  Purpose  : Self-checking bench for mix_col_seq. Four instances share one
//             input stream: COLS_PER_CYCLE 1, 2, 4 with the inverse datapath,
//             and COLS_PER_CYCLE 1 without it. A transaction-level model
//             predicts handshakes, busy and results for every instance.
//  Ports    : none
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mix_col_seq;

    localparam int NUM_DUT = 4;

    localparam logic [127:0] C_VA     = 128'hdb135345_f20a225c_01010101_2d26314c;
    localparam logic [127:0] C_VA_FWD = 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8;
    localparam logic [127:0] C_VB     = 128'h8e4da1bc_9fdc589d_c6c6c6c6_d5d5d7d6;
    localparam logic [127:0] C_VB_INV = 128'hdb135345_f20a225c_c6c6c6c6_d4d4d4d5;

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b0;
    logic         in_valid  = 1'b0;
    logic         in_inv    = 1'b0;
    logic         out_ready = 1'b0;
    logic [127:0] in_data   = '0;

    logic         in_ready_a  [NUM_DUT];
    logic         out_valid_a [NUM_DUT];
    logic         busy_a      [NUM_DUT];
    logic [127:0] out_data_a  [NUM_DUT];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic int cols_of(input int k);
        return (k == 1) ? 2 : (k == 2) ? 4 : 1;
    endfunction

    function automatic bit inv_en_of(input int k);
        return k != 3;
    endfunction

    generate
        for (genvar k = 0; k < NUM_DUT; k++) begin : g_dut
            localparam int K_COLS = (k == 1) ? 2 : (k == 2) ? 4 : 1;
            localparam bit K_INV  = (k != 3);
            mix_col_seq #(
                .COLS_PER_CYCLE(K_COLS),
                .INV_EN        (K_INV)
            ) u_dut (
                .clk      (clk),
                .rst_n    (rst_n),
                .in_valid (in_valid),
                .in_ready (in_ready_a[k]),
                .in_data  (in_data),
                .in_inv   (in_inv),
                .out_valid(out_valid_a[k]),
                .out_ready(out_ready),
                .out_data (out_data_a[k]),
                .busy     (busy_a[k])
            );
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Reference arithmetic: generic shift-and-add GF(2^8) product and the
    // circulant MixColumns matrices.
    // ------------------------------------------------------------------------
    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [3:0] m);
        logic [7:0] a;
        logic [7:0] p;
        a = a_in;
        p = 8'h00;
        for (int i = 0; i < 4; i++) begin
            if (m[i]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1B : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [127:0] ref_state(input logic [127:0] s, input bit inv);
        logic [3:0]   fwd_c [4];
        logic [3:0]   inv_c [4];
        logic [127:0] r;
        logic [7:0]   acc;
        logic [3:0]   coef;
        fwd_c = '{4'd2, 4'd3, 4'd1, 4'd1};
        inv_c = '{4'd14, 4'd11, 4'd13, 4'd9};
        r = '0;
        for (int col = 0; col < 4; col++) begin
            for (int row = 0; row < 4; row++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++) begin
                    coef = inv ? inv_c[(j - row + 4) % 4] : fwd_c[(j - row + 4) % 4];
                    acc  = acc ^ gmul(s[32*col + 31 - 8*j -: 8], coef);
                end
                r[32*col + 31 - 8*row -: 8] = acc;
            end
        end
        return r;
    endfunction

    // ------------------------------------------------------------------------
    // Comparison helpers
    // ------------------------------------------------------------------------
    task automatic check_bit(input string name, input int k, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d at %0t: got %b expected %b", name, k, $time, act, exp);
        end
    endtask

    task automatic check_word(input string name, input int k, input logic [127:0] act,
                              input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d at %0t: got %h expected %h", name, k, $time, act, exp);
        end
    endtask

    // ------------------------------------------------------------------------
    // Transaction model: a block is accepted when the slot is free, its result
    // appears N cycles later and is held until out_ready.
    // ------------------------------------------------------------------------
    int           m_left  [NUM_DUT];   // compute cycles still outstanding
    bit           m_done  [NUM_DUT];   // result waiting for out_ready
    bit           m_fresh [NUM_DUT];   // nothing accepted since reset
    logic [127:0] m_res   [NUM_DUT];

    function automatic bit exp_ready(input int k);
        return (m_left[k] == 0) && (!m_done[k] || out_ready);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        bit take;
        for (int k = 0; k < NUM_DUT; k++) begin
            if (!rst_n) begin
                m_left[k]  = 0;
                m_done[k]  = 1'b0;
                m_fresh[k] = 1'b1;
                m_res[k]   = '0;
            end else begin
                take = exp_ready(k) && in_valid;
                if (m_left[k] > 0) begin
                    m_left[k] = m_left[k] - 1;
                    if (m_left[k] == 0) m_done[k] = 1'b1;
                end else if (m_done[k] && out_ready) begin
                    m_done[k] = 1'b0;
                end
                if (take) begin
                    m_left[k]  = 4 / cols_of(k);
                    m_res[k]   = ref_state(in_data, in_inv && inv_en_of(k));
                    m_fresh[k] = 1'b0;
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < NUM_DUT; k++) begin
                check_bit("in_ready", k, in_ready_a[k], exp_ready(k));
                check_bit("out_valid", k, out_valid_a[k], m_done[k]);
                check_bit("busy", k, busy_a[k], m_left[k] > 0);
                if (m_done[k]) begin
                    check_word("out_data", k, out_data_a[k], m_res[k]);
                end else if (m_fresh[k]) begin
                    check_word("out_data_after_reset", k, out_data_a[k], 128'h0);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        // Pin the reference model to known vectors
        check_word("ref_fwd_vector", 0, ref_state(C_VA, 1'b0), C_VA_FWD);
        check_word("ref_inv_vector", 0, ref_state(C_VB, 1'b1), C_VB_INV);

        // Reset
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        for (int k = 0; k < NUM_DUT; k++) begin
            check_bit("reset_in_ready", k, in_ready_a[k], 1'b1);
            check_bit("reset_out_valid", k, out_valid_a[k], 1'b0);
            check_word("reset_out_data", k, out_data_a[k], 128'h0);
        end

        // Forward vector with a pending block held off by backpressure
        in_data  = C_VA;
        in_inv   = 1'b0;
        in_valid = 1'b1;
        tick();
        repeat (14) tick();
        for (int k = 0; k < NUM_DUT; k++) begin
            check_bit("fwd_held_valid", k, out_valid_a[k], 1'b1);
            check_word("fwd_literal", k, out_data_a[k], C_VA_FWD);
        end
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (6) tick();

        // Inverse vector; the forward-only instance yields a forward result
        out_ready = 1'b0;
        in_data   = C_VB;
        in_inv    = 1'b1;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        for (int k = 0; k < 3; k++) begin
            check_word("inv_literal", k, out_data_a[k], C_VB_INV);
        end
        out_ready = 1'b1;
        repeat (2) tick();

        // in_inv=1 on the forward-only build must be ignored
        out_ready = 1'b0;
        in_data   = C_VA;
        in_inv    = 1'b1;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        check_word("no_inv_forward", 3, out_data_a[3], C_VA_FWD);
        check_word("inv_of_va", 0, out_data_a[0], ref_state(C_VA, 1'b1));
        out_ready = 1'b1;
        repeat (2) tick();

        // Back-to-back with in_valid and out_ready held high
        in_data  = C_VA;
        in_inv   = 1'b0;
        in_valid = 1'b1;
        tick();
        in_data = C_VB;
        in_inv  = 1'b1;
        repeat (6) tick();
        in_valid = 1'b0;
        repeat (6) tick();

        // Reset while dut0 is mid-block (cnt = 2)
        in_data  = C_VB;
        in_inv   = 1'b1;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (2) tick();
        #2;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < NUM_DUT; k++) begin
            check_bit("midreset_out_valid", k, out_valid_a[k], 1'b0);
            check_bit("midreset_busy", k, busy_a[k], 1'b0);
            check_word("midreset_out_data", k, out_data_a[k], 128'h0);
        end
        tick();
        rst_n = 1'b1;
        repeat (6) tick();
        check_bit("no_valid_after_reset", 0, out_valid_a[0], 1'b0);
        in_data  = C_VA;
        in_inv   = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        check_word("after_reset_literal", 0, out_data_a[0], C_VA_FWD);
        repeat (2) tick();

        // Randomised traffic
        for (int n = 0; n < 800; n++) begin
            in_valid  = ($urandom_range(0, 99) < 60);
            out_ready = ($urandom_range(0, 99) < 65);
            in_inv    = $urandom_range(0, 1) == 1;
            in_data   = {$urandom, $urandom, $urandom, $urandom};
            tick();
        end

        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (8) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mix_col_seq.md
# mix_col_seq

Sequential, parametrised MixColumns / InvMixColumns engine for the AES datapath. It accepts one 128-bit state per valid/ready handshake and processes COLS_PER_CYCLE columns per clock. It returns the transformed state on a valid/ready output port, with forward or inverse mode selected per block. It sits between ShiftRows/InvShiftRows and AddRoundKey, and allows area-constrained builds to time-multiplex a single column multiplier.

## Interface
- COLS_PER_CYCLE, 1: columns transformed per clock; legal values are 1, 2, 4. Any other value is an elaboration error. N = 4/COLS_PER_CYCLE compute cycles.
- INV_EN, 1: 1 instantiates the InvMixColumns datapath; 0 removes it, and in_inv is then ignored (treated as 0).
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_data/in_inv are valid.
- in_ready  output  1  block can accept a state this cycle.
- in_data  input  128  state; column i = in_data[32i+31:32i], byte b0 = bits [32i+31:32i+24] … b3 = [32i+7:32i].
- in_inv  input  1  0 = MixColumns, 1 = InvMixColumns.
- out_valid  output  1  out_data holds a finished result.
- out_ready  input  1  downstream accepts out_data.
- out_data  output  128  transformed state, same column/byte layout.
- busy  output  1  state is BUSY.

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: latch in_data into the work register, latch mode (in_inv & INV_EN), clear the column counter cnt, go to BUSY.
- BUSY:
  - Each cycle, transform columns cnt*COLS_PER_CYCLE … cnt*COLS_PER_CYCLE+COLS_PER_CYCLE-1 and write them in place into the result register.
  - cnt increments by 1 per cycle.
  - After the group with cnt = N-1, go to DONE.
  - in_ready=0 throughout; in_valid is ignored.
- DONE:
  - out_valid=1; out_data is stable until out_ready.
  - On out_ready:
    - If in_valid is also high: accept the new block, go to BUSY.
    - Otherwise: go to IDLE.
- in_ready = (state==IDLE) | (state==DONE & out_ready). The out_ready→in_ready path is the only combinational path.
- Forward arithmetic, per column:
  - c0=2b0^3b1^b2^b3
  - c1=b0^2b1^3b2^b3
  - c2=b0^b1^2b2^3b3
  - c3=3b0^b1^b2^2b3
- Inverse arithmetic, per column:
  - c0=14b0^11b1^13b2^9b3
  - c1=9b0^14b1^11b2^13b3
  - c2=13b0^9b1^14b2^11b3
  - c3=11b0^13b1^9b2^14b3
- All multiplications are in GF(2^8) mod x^8+x^4+x^3+x+1.
  - xtime(x) = {x[6:0],1'b0} ^ (x[7] ? 8'h1B : 8'h00).
  - 9, 11, 13, 14 are built from chained xtime plus XOR.
- Results are 8-bit per byte; there is no carry out of any byte.
- Mode is latched per block; changing in_inv while BUSY has no effect.

## Timing
- Reset (rst_n=0, any state, including mid-BUSY):
  - state IDLE, cnt=0.
  - out_valid=0, busy=0, out_data=128'h0.
  - in_ready=1 from the first cycle after rst_n deasserts.
  - Any partially processed block is discarded.
- Latency: accept on edge T → out_valid=1 after edge T+N. Concretely: N=4 → 4 cycles, N=2 → 2 cycles, N=1 → 1 cycle.
- Throughput with out_ready held high: one block per N+1 cycles (DONE overlaps the next accept).
- Backpressure: out_valid is held and out_data is frozen for any number of cycles while out_ready=0. No new block is accepted during that time.
- out_data equals the result register. Bytes not yet processed are never visible, because out_valid=0 until DONE.
- out_ready is ignored when out_valid=0.

## Test plan
- Forward, COLS_PER_CYCLE=1: in_data=128'hdb135345_f20a225c_01010101_2d26314c, in_inv=0 → out_data=128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8. out_valid rises exactly 4 cycles after accept; busy is high for 4 cycles.
- Inverse: in_data=128'h8e4da1bc_9fdc589d_c6c6c6c6_d5d5d7d6, in_inv=1 → 128'hdb135345_f20a225c_c6c6c6c6_d4d4d4d5. Repeat with COLS_PER_CYCLE=2 (latency 2) and 4 (latency 1).
- Back-to-back: two blocks with in_valid and out_ready held high. The second is accepted in the cycle the first completes its output handshake; the outputs are separated by N+1 cycles and are both correct.
- Backpressure: out_ready=0 for 10 cycles after out_valid. out_valid and out_data stay constant, in_ready=0, and a pending in_valid is not accepted until out_ready=1.
- Reset mid-BUSY: assert rst_n=0 at cnt=2 (COLS_PER_CYCLE=1). Outputs go to zero immediately (asynchronously), with no out_valid afterwards. A new block after reset gives a correct result.
- INV_EN=0: in_inv=1 with 128'hdb135345_f20a225c_01010101_2d26314c → the forward result 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8.
